// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared widths and FSM state encoding for the shift-and-add multiplier
package arith_pkg;

  localparam int MULT_W = 5;
  localparam int PROD_W = 2 * MULT_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/rca.sv
// rtl/rca.sv - parameterized ripple-carry adder
module rca #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  // Full-adder chain, carry rippling from bit 0 upward.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/seq_mult5.sv
// rtl/seq_mult5.sv - sequential unsigned shift-and-add multiplier, one partial product per clock
module seq_mult5
  import arith_pkg::*;
#(
  parameter int N = MULT_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplr;
  // The accumulator's bit above N-1 is always zero after the right shift,
  // so only the low N bits are stored; the adder carry lands in acc[N-1].
  logic [N-1:0]  acc;
  logic [CW-1:0] count;

  logic [N-1:0]  gated;
  logic [N-1:0]  sum_lo;
  logic          sum_c;
  logic [N-1:0]  acc_next;
  logic [N-1:0]  mplr_next;

  assign gated = mcand & {N{mplr[0]}};

  rca #(.W(N)) u_rca (
    .a    (acc),
    .b    (gated),
    .cin  (1'b0),
    .sum  (sum_lo),
    .cout (sum_c)
  );

  // {acc, mplr} <- {carry, sum, mplr} >> 1
  assign acc_next  = {sum_c, sum_lo[N-1:1]};
  assign mplr_next = {sum_lo[0], mplr[N-1:1]};

  // Control FSM plus operand, accumulator, counter and product registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= a;
            mplr  <= b;
            acc   <= '0;
            count <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          mplr  <= mplr_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            product <= {acc_next, mplr_next};
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
